// File: rtl/fetch_stage_if.sv
// Fetch-stage control/program-load/issue bundle: the debug/pipeline side drives
// the i_* controls and consumes the o_* issue signals.
interface fetch_stage_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
);
    logic               i_valid;
    logic               i_stall;
    logic               i_start;
    logic               i_clear;
    logic               i_jump;
    logic [NB_DATA-1:0] i_jump_address;
    logic               i_write_enable;
    logic [NB_ADDR-1:0] i_write_address;
    logic [NB_DATA-1:0] i_write_data;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_DATA-1:0] o_pc_next;
    logic [NB_DATA-1:0] o_pc;
    logic               o_running;
    logic               o_halt;

    modport master (
        output i_valid, i_stall, i_start, i_clear, i_jump, i_jump_address,
               i_write_enable, i_write_address, i_write_data,
        input  o_instruction, o_pc_next, o_pc, o_running, o_halt
    );

    modport slave (
        input  i_valid, i_stall, i_start, i_clear, i_jump, i_jump_address,
               i_write_enable, i_write_address, i_write_data,
        output o_instruction, o_pc_next, o_pc, o_running, o_halt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, word-organised program memory and a
// load/run/halt controller that stops fetching on the HALT word.
module fetch_stage #(
    parameter int unsigned        NB_DATA   = 32,
    parameter int unsigned        NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = '1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    fetch_stage_if.slave bus
);
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc_next_q, pc_next_d;

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    logic [NB_ADDR-1:0] fetch_idx;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] jump_target;
    logic               advance;
    logic               mem_we;

    // Word index ignores the upper PC bits, so fetch wraps modulo the memory depth.
    assign fetch_idx   = pc_q[NB_ADDR+1:2];
    assign fetch_word  = mem[fetch_idx];
    assign pc_plus4    = pc_q + NB_DATA'(4);
    assign jump_target = bus.i_jump_address & ~NB_DATA'(3);
    assign advance     = bus.i_valid & ~bus.i_stall;
    assign mem_we      = (state_q == ST_LOAD) & bus.i_write_enable;

    // Program memory survives reset so a program can be re-run after a reset.
    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem[bus.i_write_address] <= bus.i_write_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.i_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (advance) begin
                    instr_d   = fetch_word;
                    pc_next_d = pc_plus4;
                    // HALT is still issued, but the PC parks on it.
                    if (fetch_word == HALT_WORD) state_d = ST_HALTED;
                    else if (bus.i_jump)         pc_d    = jump_target;
                    else                         pc_d    = pc_plus4;
                end
            end
            ST_HALTED: begin
                if (bus.i_clear) begin
                    state_d = ST_LOAD;
                    pc_d    = '0;
                    instr_d = '0;
                end else if (advance) begin
                    instr_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_LOAD;
            pc_q      <= '0;
            instr_q   <= '0;
            pc_next_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pc_next     = pc_next_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_running     = (state_q == ST_RUN);
    assign bus.o_halt        = (state_q == ST_HALTED);
endmodule
